// File: rtl/bolme_denetleyici.sv
// ============================================================================
// bolme_denetleyici : execute-stage <-> iterative divider sequencer.
// Optional one-entry result cache: define BOLME_ONBELLEK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module bolme_denetleyici (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        istek_gecerli_i,
  output logic        istek_hazir_o,
  input  logic [1:0]  islem_i,
  input  logic [31:0] bolunen_i,
  input  logic [31:0] bolen_i,
  input  logic        iptal_i,
  output logic        sonuc_gecerli_o,
  output logic [31:0] sonuc_o,
  input  logic        sonuc_al_i,
  output logic        bolme_basla_o,
  output logic [1:0]  bolme_islem_o,
  output logic [31:0] bolme_bolunen_o,
  output logic [31:0] bolme_bolen_o,
  input  logic        bolme_bitti_i,
  input  logic [31:0] bolme_sonuc_i
);

  typedef enum logic [1:0] {
    BOSTA   = 2'd0,
    BOLUYOR = 2'd1,
    SONUC   = 2'd2
  } durum_t;

  durum_t      r_durum;
  logic        r_basla;
  logic [1:0]  r_islem;
  logic [31:0] r_bolunen;
  logic [31:0] r_bolen;
  logic        r_sonuc_gecerli;
  logic [31:0] r_sonuc;
  logic        w_kabul;
  logic        w_isabet;
  logic [31:0] w_onb_sonuc;

  assign istek_hazir_o = (r_durum == BOSTA) & ~iptal_i;
  assign w_kabul       = istek_gecerli_i & istek_hazir_o;

`ifdef BOLME_ONBELLEK_EN
  logic        r_onb_gecerli;
  logic [1:0]  r_onb_islem;
  logic [31:0] r_onb_bolunen;
  logic [31:0] r_onb_bolen;
  logic [31:0] r_onb_sonuc;

  assign w_isabet = r_onb_gecerli & (islem_i == r_onb_islem) &
                    (bolunen_i == r_onb_bolunen) & (bolen_i == r_onb_bolen);
  assign w_onb_sonuc = r_onb_sonuc;

  // Only a completed, unflushed division refreshes the entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_onb_gecerli <= 1'b0;
      r_onb_islem   <= 2'd0;
      r_onb_bolunen <= 32'd0;
      r_onb_bolen   <= 32'd0;
      r_onb_sonuc   <= 32'd0;
    end else if ((r_durum == BOLUYOR) && bolme_bitti_i && !iptal_i) begin
      r_onb_gecerli <= 1'b1;
      r_onb_islem   <= r_islem;
      r_onb_bolunen <= r_bolunen;
      r_onb_bolen   <= r_bolen;
      r_onb_sonuc   <= bolme_sonuc_i;
    end
  end
`else
  assign w_isabet    = 1'b0;
  assign w_onb_sonuc = 32'd0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_durum         <= BOSTA;
      r_basla         <= 1'b0;
      r_islem         <= 2'd0;
      r_bolunen       <= 32'd0;
      r_bolen         <= 32'd0;
      r_sonuc_gecerli <= 1'b0;
      r_sonuc         <= 32'd0;
    end else if (iptal_i) begin
      r_durum         <= BOSTA;
      r_basla         <= 1'b0;
      r_sonuc_gecerli <= 1'b0;
    end else begin
      case (r_durum)
        BOSTA: begin
          if (w_kabul) begin
            r_islem   <= islem_i;
            r_bolunen <= bolunen_i;
            r_bolen   <= bolen_i;
            if (w_isabet) begin
              r_sonuc         <= w_onb_sonuc;
              r_sonuc_gecerli <= 1'b1;
              r_durum         <= SONUC;
            end else begin
              r_basla <= 1'b1;
              r_durum <= BOLUYOR;
            end
          end
        end
        BOLUYOR: begin
          // Dropping start here guarantees the idle cycle the divider needs.
          if (bolme_bitti_i) begin
            r_sonuc         <= bolme_sonuc_i;
            r_basla         <= 1'b0;
            r_sonuc_gecerli <= 1'b1;
            r_durum         <= SONUC;
          end
        end
        SONUC: begin
          if (sonuc_al_i) begin
            r_sonuc_gecerli <= 1'b0;
            r_durum         <= BOSTA;
          end
        end
        default: begin
          r_basla         <= 1'b0;
          r_sonuc_gecerli <= 1'b0;
          r_durum         <= BOSTA;
        end
      endcase
    end
  end

  assign bolme_basla_o   = r_basla;
  assign bolme_islem_o   = r_islem;
  assign bolme_bolunen_o = r_bolunen;
  assign bolme_bolen_o   = r_bolen;
  assign sonuc_gecerli_o = r_sonuc_gecerli;
  assign sonuc_o         = r_sonuc;

endmodule

`default_nettype wire

// File: tb/tb_bolme_denetleyici.sv
// Bench for bolme_denetleyici with a 19-cycle iterative divider model.
`default_nettype none

module tb_bolme_denetleyici;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        istek_gecerli_i = 1'b0;
  logic        istek_hazir_o;
  logic [1:0]  islem_i = 2'd0;
  logic [31:0] bolunen_i = 32'd0;
  logic [31:0] bolen_i = 32'd0;
  logic        iptal_i = 1'b0;
  logic        sonuc_gecerli_o;
  logic [31:0] sonuc_o;
  logic        sonuc_al_i = 1'b0;
  logic        bolme_basla_o;
  logic [1:0]  bolme_islem_o;
  logic [31:0] bolme_bolunen_o;
  logic [31:0] bolme_bolen_o;
  logic        bolme_bitti_i;
  logic [31:0] bolme_sonuc_i;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  bolme_denetleyici dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .istek_gecerli_i(istek_gecerli_i), .istek_hazir_o(istek_hazir_o),
    .islem_i(islem_i), .bolunen_i(bolunen_i), .bolen_i(bolen_i),
    .iptal_i(iptal_i),
    .sonuc_gecerli_o(sonuc_gecerli_o), .sonuc_o(sonuc_o), .sonuc_al_i(sonuc_al_i),
    .bolme_basla_o(bolme_basla_o), .bolme_islem_o(bolme_islem_o),
    .bolme_bolunen_o(bolme_bolunen_o), .bolme_bolen_o(bolme_bolen_o),
    .bolme_bitti_i(bolme_bitti_i), .bolme_sonuc_i(bolme_sonuc_i)
  );

  always #5 clk_i = ~clk_i;

  // Divider model: done in the 19th cycle of a held start, clears while start is low.
  int div_cnt = 0;
  always @(posedge clk_i) begin
    if (!bolme_basla_o) div_cnt <= 0;
    else                div_cnt <= div_cnt + 1;
  end

  function automatic logic [31:0] div_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0:    div_ref = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd1:    div_ref = (b == 0) ? a : a % b;
      2'd2:    div_ref = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
      default: div_ref = (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
    endcase
  endfunction

  assign bolme_bitti_i = bolme_basla_o && (div_cnt == 18);
  assign bolme_sonuc_i = bolme_bitti_i ? div_ref(bolme_islem_o, bolme_bolunen_o, bolme_bolen_o)
                                       : 32'hDEAD_BEEF;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every result actually taken by the consumer is popped and compared.
  always @(negedge clk_i) begin
    if (!rst_i && !iptal_i && sonuc_gecerli_o && sonuc_al_i) begin
      if (exp_q.size() == 0) begin
        check32("unexpected_result", sonuc_o, 32'hXXXX_XXXX);
      end else begin
        check32("scoreboard_result", sonuc_o, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int c;
    c = 0;
    while (!istek_hazir_o && c < 60) begin step(); c++; end
    check32("ready_before_accept", {31'd0, istek_hazir_o}, 32'd1);
    istek_gecerli_i = 1'b1;
    islem_i = op; bolunen_i = a; bolen_i = b;
    step();
    istek_gecerli_i = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int hold, input int exp_lat);
    int c, basla_cnt;
    sonuc_al_i = (hold == 0);
    exp_q.push_back(exp);
    accept(op, a, b);
    check32("latched_dividend", bolme_bolunen_o, a);
    check32("latched_divisor", bolme_bolen_o, b);
    c = 1; basla_cnt = 0;
    while (!sonuc_gecerli_o && c < 100) begin
      if (bolme_basla_o) basla_cnt++;
      step(); c++;
    end
    check32("result_latency", c, exp_lat);
    check32("start_cycles", basla_cnt, (exp_lat == 1) ? 32'd0 : 32'd19);
    check32("start_low_at_result", {31'd0, bolme_basla_o}, 32'd0);
    for (int i = 0; i < hold; i++) begin
      check32("held_result", sonuc_o, exp);
      check32("ready_low_backpressure", {31'd0, istek_hazir_o}, 32'd0);
      check32("valid_held", {31'd0, sonuc_gecerli_o}, 32'd1);
      step();
    end
    sonuc_al_i = 1'b1;
    step();
    sonuc_al_i = 1'b0;
    check32("valid_drop_after_take", {31'd0, sonuc_gecerli_o}, 32'd0);
    check32("ready_after_take", {31'd0, istek_hazir_o}, 32'd1);
  endtask

  task automatic expect_silence(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      if (sonuc_gecerli_o) seen++;
      step();
    end
    check32("no_result_after_flush", seen, 32'd0);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          hold;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int c;
    vecs[0] = '{2'd0, 32'd100,        32'd7,          32'd14,         0};
    vecs[1] = '{2'd3, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  0};
    vecs[2] = '{2'd2, 32'd5,          32'd0,          32'hFFFF_FFFF,  0};
    vecs[3] = '{2'd1, 32'd5,          32'd0,          32'd5,          0};
    vecs[4] = '{2'd2, 32'hFFFF_FF9C,  32'd10,         32'hFFFF_FFF6,  5};
    vecs[5] = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0};
    vecs[6] = '{2'd3, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2};

    step(); step();
    check32("reset_basla", {31'd0, bolme_basla_o}, 32'd0);
    check32("reset_valid", {31'd0, sonuc_gecerli_o}, 32'd0);
    check32("reset_sonuc", sonuc_o, 32'd0);
    check32("reset_dividend", bolme_bolunen_o, 32'd0);
    rst_i = 1'b0;
    step();
    check32("ready_idle", {31'd0, istek_hazir_o}, 32'd1);
    iptal_i = 1'b1; #1;
    check32("ready_masked_by_flush", {31'd0, istek_hazir_o}, 32'd0);
    iptal_i = 1'b0;
    step();

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold, 20);

    // Flush in cycle 6 of DIVU 50/5.
    accept(2'd0, 32'd50, 32'd5);
    for (int i = 1; i < 6; i++) step();
    iptal_i = 1'b1;
    step();
    iptal_i = 1'b0;
    check32("flush_start_low", {31'd0, bolme_basla_o}, 32'd0);
    check32("flush_valid_low", {31'd0, sonuc_gecerli_o}, 32'd0);
    expect_silence(30);
    run_op(2'd0, 32'd9, 32'd3, 32'd3, 0, 20);

    // Flush coinciding with divider done.
    accept(2'd0, 32'd8, 32'd2);
    c = 0;
    while (!bolme_bitti_i && c < 40) begin step(); c++; end
    check32("done_seen", {31'd0, bolme_bitti_i}, 32'd1);
    iptal_i = 1'b1;
    step();
    iptal_i = 1'b0;
    check32("flush_at_done_valid", {31'd0, sonuc_gecerli_o}, 32'd0);
    check32("flush_at_done_start", {31'd0, bolme_basla_o}, 32'd0);
    expect_silence(10);
    run_op(2'd0, 32'd8, 32'd2, 32'd4, 0, 20);

    // Asynchronous reset mid-division.
    accept(2'd3, 32'd77, 32'd5);
    for (int i = 0; i < 5; i++) step();
    check32("busy_before_reset", {31'd0, bolme_basla_o}, 32'd1);
    rst_i = 1'b1; #1;
    check32("rst_basla", {31'd0, bolme_basla_o}, 32'd0);
    check32("rst_islem", {30'd0, bolme_islem_o}, 32'd0);
    check32("rst_dividend", bolme_bolunen_o, 32'd0);
    check32("rst_divisor", bolme_bolen_o, 32'd0);
    check32("rst_sonuc", sonuc_o, 32'd0);
    check32("rst_valid", {31'd0, sonuc_gecerli_o}, 32'd0);
    step();
    rst_i = 1'b0;
    step();
    expect_silence(5);

`ifdef BOLME_ONBELLEK_EN
    run_op(2'd0, 32'd100, 32'd7, 32'd14, 0, 20);
    run_op(2'd0, 32'd100, 32'd7, 32'd14, 0, 1);
    run_op(2'd1, 32'd100, 32'd7, 32'd2, 0, 20);
`else
    run_op(2'd0, 32'd100, 32'd7, 32'd14, 0, 20);
    run_op(2'd0, 32'd100, 32'd7, 32'd14, 0, 20);
`endif

    step();
    check32("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/bolme_denetleyici.md
# bolme_denetleyici

Sequencer between the execute stage and the iterative divider. It accepts one DIV/DIVU/REM/REMU request through a valid/ready handshake and holds operands and start stable for the whole division. It captures the divider's single-cycle result and presents it with backpressure until the consumer takes it. It supports pipeline flush at any point and, optionally, returns a repeated operation from a one-entry result cache without running the divider.

## Interface
Parameters: none.

- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- istek_gecerli_i  in  1  request valid
- istek_hazir_o  out  1  request ready; combinational, `(durum==BOSTA) & !iptal_i`
- islem_i  in  2  00 DIVU, 01 REMU, 10 DIV, 11 REM
- bolunen_i  in  32  dividend
- bolen_i  in  32  divisor
- iptal_i  in  1  flush; discards any request in flight
- sonuc_gecerli_o  out  1  result valid (registered)
- sonuc_o  out  32  result (registered)
- sonuc_al_i  in  1  consumer takes result this cycle
- bolme_basla_o  out  1  divider start/hold (registered)
- bolme_islem_o  out  2  operation to divider (registered)
- bolme_bolunen_o  out  32  dividend to divider (registered)
- bolme_bolen_o  out  32  divisor to divider (registered)
- bolme_bitti_i  in  1  divider done; high in its final cycle while start is held
- bolme_sonuc_i  in  32  divider result; valid only in the cycle bolme_bitti_i is high with start held

## Operation
- States: BOSTA, BOLUYOR, SONUC.
- BOSTA: a request is accepted when `istek_gecerli_i & istek_hazir_o`. On accept:
  - islem and operands are latched into the bolme_* registers.
  - On a cache miss, or with the cache compiled out, the next state is BOLUYOR and bolme_basla_o=1.
  - On a cache hit, the cached result is loaded into sonuc_o and the next state is SONUC.
- BOLUYOR:
  - bolme_basla_o stays 1 and the bolme_* operands stay constant.
  - When bolme_bitti_i=1: bolme_sonuc_i is registered into sonuc_o, bolme_basla_o drops to 0 on the same edge, and the next state is SONUC.
  - The FSM never depends on a fixed iteration count.
- SONUC:
  - sonuc_gecerli_o=1 and sonuc_o is held stable.
  - On sonuc_al_i=1 the next state is BOSTA and sonuc_gecerli_o=0 next cycle.
  - A new request cannot be accepted in the same cycle as sonuc_al_i; ready only rises in BOSTA.
- bolme_basla_o is 0 in every state except BOLUYOR. It must go low for at least one cycle between divisions, because the divider's internal state clears only while start is low.
- iptal_i, in any state: next state is BOSTA, and bolme_basla_o=0 and sonuc_gecerli_o=0 next cycle.
  - A result arriving in that cycle is dropped.
  - The cache is not updated.
  - iptal_i beats sonuc_al_i and istek_gecerli_i in the same cycle.
- Divide-by-zero and overflow results are whatever the divider returns (DIV/DIVU by 0 → 0xFFFFFFFF; REM/REMU by 0 → dividend). The controller does not special-case them.

## Timing
- Reset (async, immediate):
  - state BOSTA.
  - bolme_basla_o=0, bolme_islem_o=0, bolme_bolunen_o=0, bolme_bolen_o=0.
  - sonuc_gecerli_o=0, sonuc_o=0.
  - Cache valid=0.
- Reset mid-division aborts it; the divider clears because start is low.
- Miss latency, with the accept edge as cycle 0:
  - bolme_basla_o high in cycles 1..19.
  - Divider bitti in cycle 19.
  - sonuc_gecerli_o high from cycle 20.
- Hit latency: sonuc_gecerli_o high from cycle 1.
- Back-to-back throughput: one result per 21 cycles on a miss when the consumer takes the result immediately (20 + 1 BOSTA cycle).
- istek_hazir_o is combinational from the state and iptal_i. All other outputs are registered.

## Configuration
- BOLME_ONBELLEK_EN defined:
  - One-entry cache holding {islem, bolunen, bolen, sonuc} plus a valid bit.
  - The entry is written when a BOLUYOR→SONUC transition completes without iptal_i.
  - Hit requires all 66 key bits to match and valid=1.
  - The entry is cleared only by reset.
- BOLME_ONBELLEK_EN undefined:
  - No cache registers exist.
  - Every request goes through BOLUYOR.

## Test plan
- DIVU 100/7, sonuc_al_i tied high → bolme_basla_o high cycles 1..19; sonuc_o=14, sonuc_gecerli_o high at cycle 20 for one cycle; then back to BOSTA.
- REM 0xFFFFFFF9 (−7) / 2 → sonuc_o=0xFFFFFFFF. DIV 5/0 → 0xFFFFFFFF. REMU 5/0 → 5.
- Backpressure: DIV 0xFFFFFF9C (−100) / 10 with sonuc_al_i low for 5 cycles → sonuc_o=0xFFFFFFF6 held stable with sonuc_gecerli_o high and istek_hazir_o low; ready rises the cycle after the take.
- Flush: iptal_i in cycle 6 of DIVU 50/5 → bolme_basla_o low in cycle 7; no result ever appears. Next DIVU 9/3 → 3 with full 20-cycle latency.
- Flush and reset corner cases:
  - iptal_i in the same cycle as bolme_bitti_i → no sonuc_gecerli_o.
  - rst_i pulse mid-BOLUYOR → all outputs 0 immediately.
- With BOLME_ONBELLEK_EN: DIVU 100/7 twice → second result 14 at cycle 1 with bolme_basla_o never high. Then REMU 100/7 → miss, 2 after 20 cycles.
